// File: rtl/fanout_fork_buffer_if.sv
// Stream-in / fanout-out bundle for the fork buffer.
// The buffer side uses the slave modport; the driving environment uses master.
interface fanout_fork_buffer_if #(
  parameter int unsigned NUM_OUT    = 9,
  parameter int unsigned DATA_WIDTH = 17
) ();
  logic [NUM_OUT-1:0]    en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [NUM_OUT-1:0]    valid_out;
  logic [NUM_OUT-1:0]    ready_in;

  modport slave (
    input  en,
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output valid_out,
    input  ready_in
  );

  modport master (
    output en,
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  valid_out,
    output ready_in
  );
endinterface

// File: rtl/fanout_fork_buffer.sv
// Two-entry ready/valid buffer with an eager fork to NUM_OUT branches.
// Each word is held until every enabled branch has taken it; disabled
// branches count as already served. Upstream ready is registered so the
// branch-ready reduction stays out of the upstream combinational path.
module fanout_fork_buffer #(
  parameter int unsigned NUM_OUT    = 9,
  parameter int unsigned DATA_WIDTH = 17
) (
  input  logic clk,
  input  logic rst_n,
  fanout_fork_buffer_if.slave bus
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [NUM_OUT-1:0]    done;
  logic                  ready_q;

  logic                  not_empty;
  logic [NUM_OUT-1:0]    valid_vec;
  logic [NUM_OUT-1:0]    fire;
  logic                  all_served;
  logic                  push;
  logic                  pop;
  logic [1:0]            next_count;

  // Branch valids, handshakes and FIFO control, all from registered state
  always_comb begin
    not_empty  = (count != 2'd0);
    valid_vec  = {NUM_OUT{not_empty}} & bus.en & ~done;
    fire       = valid_vec & bus.ready_in;
    all_served = &(done | fire | ~bus.en);
    push       = bus.valid_in & ready_q;
    pop        = not_empty & all_served;
    next_count = count + {1'b0, push} - {1'b0, pop};
  end

  assign bus.valid_out = valid_vec;
  assign bus.data_out  = mem[rd_ptr];
  assign bus.ready_out = ready_q;

  // Pointer, occupancy, served-flag and registered upstream-ready state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      done    <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        done   <= '0;
      end else begin
        done <= done | fire;
      end
      count   <= next_count;
      ready_q <= (next_count != 2'd2);
    end
  end

  // Payload storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

endmodule

// File: tb/tb_fanout_fork_buffer.sv
// Directed bench for fanout_fork_buffer: fork, partial service, fill,
// drop mode, full-with-pop and asynchronous reset.
module tb_fanout_fork_buffer;

  localparam int unsigned NUM_OUT    = 9;
  localparam int unsigned DATA_WIDTH = 17;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fanout_fork_buffer_if #(.NUM_OUT(NUM_OUT), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fanout_fork_buffer #(.NUM_OUT(NUM_OUT), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    bus.en       = '0;
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = '0;
    rst_n        = 1'b0;
    #12 rst_n    = 1'b1;
    tick();

    // 1: full fork, back-to-back words
    check("rst_ready", 32'(bus.ready_out), 32'h1);
    check("rst_valid", 32'(bus.valid_out), 32'h0);
    check("rst_count", 32'(dut.count), 32'h0);
    bus.en = 9'h1FF; bus.ready_in = 9'h1FF;
    bus.data_in = 17'h00011; bus.valid_in = 1'b1;
    tick();
    check("t1_a_valid", 32'(bus.valid_out), 32'h1FF);
    check("t1_a_data", 32'(bus.data_out), 32'h00011);
    check("t1_a_ready", 32'(bus.ready_out), 32'h1);
    bus.data_in = 17'h00022;
    tick();
    bus.valid_in = 1'b0;
    check("t1_b_valid", 32'(bus.valid_out), 32'h1FF);
    check("t1_b_data", 32'(bus.data_out), 32'h00022);
    check("t1_b_ready", 32'(bus.ready_out), 32'h1);
    tick();
    check("t1_count", 32'(dut.count), 32'h0);
    check("t1_idle", 32'(bus.valid_out), 32'h0);

    // 2: branch 1 stalls three cycles
    bus.en = 9'h003; bus.ready_in = 9'h001;
    bus.data_in = 17'h0ABCD; bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("t2_c1_valid", 32'(bus.valid_out), 32'h003);
    check("t2_c1_data", 32'(bus.data_out), 32'h0ABCD);
    tick();
    check("t2_c2_valid", 32'(bus.valid_out), 32'h002);
    tick();
    check("t2_c3_valid", 32'(bus.valid_out), 32'h002);
    tick();
    check("t2_c4_valid", 32'(bus.valid_out), 32'h002);
    check("t2_c4_data", 32'(bus.data_out), 32'h0ABCD);
    bus.ready_in = 9'h003;
    tick();
    check("t2_pop_valid", 32'(bus.valid_out), 32'h0);
    check("t2_pop_count", 32'(dut.count), 32'h0);
    check("t2_pop_done", 32'(dut.done), 32'h0);

    // 3: fill with no consumer ready, then drain in order
    bus.en = 9'h001; bus.ready_in = 9'h000;
    bus.valid_in = 1'b1; bus.data_in = 17'h00101;
    tick();
    check("t3_ready_1", 32'(bus.ready_out), 32'h1);
    bus.data_in = 17'h00102;
    tick();
    check("t3_ready_full", 32'(bus.ready_out), 32'h0);
    check("t3_count_2", 32'(dut.count), 32'h2);
    bus.data_in = 17'h00103;
    tick();
    bus.data_in = 17'h00104;
    tick();
    bus.valid_in = 1'b0;
    check("t3_count_held", 32'(dut.count), 32'h2);
    check("t3_head", 32'(bus.data_out), 32'h00101);
    check("t3_head_valid", 32'(bus.valid_out), 32'h001);
    bus.ready_in = 9'h001;
    tick();
    check("t3_second", 32'(bus.data_out), 32'h00102);
    check("t3_second_valid", 32'(bus.valid_out), 32'h001);
    check("t3_ready_back", 32'(bus.ready_out), 32'h1);
    check("t3_count_1", 32'(dut.count), 32'h1);
    tick();
    check("t3_drained", 32'(dut.count), 32'h0);
    check("t3_drained_valid", 32'(bus.valid_out), 32'h0);

    // 4: all branches disabled drops the word
    bus.en = 9'h000; bus.ready_in = 9'h000;
    bus.data_in = 17'h1FFFF; bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("t4_valid", 32'(bus.valid_out), 32'h0);
    check("t4_count_1", 32'(dut.count), 32'h1);
    check("t4_data", 32'(bus.data_out), 32'h1FFFF);
    check("t4_ready", 32'(bus.ready_out), 32'h1);
    tick();
    check("t4_count_0", 32'(dut.count), 32'h0);
    check("t4_ready_after", 32'(bus.ready_out), 32'h1);

    // 5: full buffer, last branch fires while upstream is valid
    bus.en = 9'h003; bus.ready_in = 9'h000;
    bus.valid_in = 1'b1; bus.data_in = 17'h00201;
    tick();
    bus.data_in = 17'h00202;
    tick();
    bus.valid_in = 1'b0;
    check("t5_full_ready", 32'(bus.ready_out), 32'h0);
    bus.ready_in = 9'h001;
    tick();
    check("t5_partial_valid", 32'(bus.valid_out), 32'h002);
    check("t5_partial_count", 32'(dut.count), 32'h2);
    bus.ready_in = 9'h002; bus.valid_in = 1'b1; bus.data_in = 17'h00203;
    tick();
    check("t5_no_accept", 32'(dut.count), 32'h1);
    check("t5_ready_back", 32'(bus.ready_out), 32'h1);
    check("t5_next_head", 32'(bus.data_out), 32'h00202);
    check("t5_next_valid", 32'(bus.valid_out), 32'h003);
    bus.ready_in = 9'h000;
    tick();
    bus.valid_in = 1'b0;
    check("t5_accept", 32'(dut.count), 32'h2);
    check("t5_head_kept", 32'(bus.data_out), 32'h00202);
    bus.ready_in = 9'h003;
    tick();
    check("t5_wrap_head", 32'(bus.data_out), 32'h00203);
    check("t5_wrap_count", 32'(dut.count), 32'h1);
    tick();
    check("t5_empty", 32'(dut.count), 32'h0);

    // 6: asynchronous reset with two words and partial service
    bus.en = 9'h007; bus.ready_in = 9'h000;
    bus.valid_in = 1'b1; bus.data_in = 17'h00301;
    tick();
    bus.data_in = 17'h00302;
    tick();
    bus.valid_in = 1'b0;
    bus.ready_in = 9'h005;
    tick();
    bus.ready_in = 9'h000;
    check("t6_done", 32'(dut.done), 32'h005);
    check("t6_count", 32'(dut.count), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.valid_out), 32'h0);
    check("t6_rst_ready", 32'(bus.ready_out), 32'h1);
    check("t6_rst_count", 32'(dut.count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.valid_in = 1'b1; bus.data_in = 17'h00401;
    tick();
    bus.valid_in = 1'b0;
    check("t6_new_valid", 32'(bus.valid_out), 32'h007);
    check("t6_new_data", 32'(bus.data_out), 32'h00401);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
